regfile_dump: RTL and testbench
===============================

# regfile_dump

Sequential reader for the 32×32-bit register file. On a start pulse it walks a contiguous, possibly wrapping, range of register addresses through one register-file read port. It streams each {address, data} pair out over a valid/ready handshake. It sits beside the datapath register file and feeds debug dump, state save and test-bench checkers, using a read port the core does not own during the dump.

## Interface
Parameters:
- RD_LAT, default 1: register-file read latency in cycles, ≥1. rf_rd_data is valid RD_LAT cycles after rf_rd_addr changes.

Ports:
- elk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- start, input, 1: one-cycle request to begin a dump; sampled only in IDLE.
- first_addr, input, 5: first register of the range; latched on accepted start.
- last_addr, input, 5: last register of the range; latched on accepted start.
- busy, output, 1: dump in progress.
- done, output, 1: one-cycle pulse after the final transfer.
- rf_rd_addr, output, 5: address to the register-file read port; registered.
- rf_rd_data, input, 32: read data from the register file.
- dump_valid, output, 1: dump_addr/dump_data hold a valid entry.
- dump_ready, input, 1: downstream accepts the entry.
- dump_addr, output, 5: register number of the current entry.
- dump_data, output, 32: register contents of the current entry.

## Operation
- States: IDLE, READ, OUT, DONE.
- IDLE, on start=1:
  - rf_rd_addr ← first_addr; latch last_addr; wait counter ← RD_LAT−1; go to READ.
  - start=0 keeps the block in IDLE.
- READ:
  - Hold rf_rd_addr stable; decrement the wait counter each cycle.
  - At the edge where the counter is 0: dump_data ← rf_rd_data, dump_addr ← rf_rd_addr, go to OUT.
- OUT:
  - dump_valid=1.
  - dump_addr and dump_data are held stable until dump_valid & dump_ready at a rising edge.
  - On transfer, if dump_addr == latched last: go to DONE.
  - Otherwise: rf_rd_addr ← rf_rd_addr+1 mod 32, wait counter ← RD_LAT−1, go to READ.
- DONE: done=1 for exactly one cycle, then IDLE.
- Range arithmetic:
  - 5-bit increment with wrap 31→0.
  - Entry count = ((last − first) mod 32) + 1.
  - first==last → 1 entry; last==first−1 → all 32 entries.
  - last<first wraps, e.g. 30..1 → 30,31,0,1.
- busy=1 in READ, OUT and DONE; 0 in IDLE.
- start while busy is ignored, not queued. first_addr/last_addr changes during a dump have no effect.
- dump_ready while dump_valid=0 is ignored.
- The block never writes the register file.

## Timing
- Reset (rst=1 at an edge, any state, including mid-dump):
  - State → IDLE; busy=0, done=0, dump_valid=0, rf_rd_addr=0, dump_addr=0, dump_data=0.
  - An in-flight entry is discarded, not completed.
  - rst has priority over start in the same cycle.
- start accepted at edge T0: busy=1 and rf_rd_addr=first from T0+; first dump_valid=1 after edge T0+RD_LAT.
- Per entry with dump_ready held high: RD_LAT+1 cycles.
  - Full 32-entry dump with RD_LAT=1: 64 cycles from start edge to final transfer; done pulse in the following cycle.
- Backpressure: dump_ready=0 stalls in OUT indefinitely; rf_rd_addr stays at the current entry.
- Transfer and next address are the same edge: on the transfer edge rf_rd_addr advances and dump_valid drops.
- done and busy: after the DONE cycle both are 0; a start in the DONE cycle is ignored. Earliest restart is the cycle after done.
- dump_valid, dump_addr, dump_data, busy and done are registered outputs (no combinational input-to-output path).

## Test plan
- Reset then idle, RD_LAT=1, ready=1, register file r[i]=i*0x11111111:
  - start with first=0, last=31 → 32 entries, addr 0..31, data i*0x11111111.
  - Each entry valid 1 cycle every 2; done pulses once at cycle 65 after start; busy low afterwards.
- Wrap and single entry:
  - first=30, last=1 → entries 30,31,0,1 then done.
  - first=5, last=5 → exactly one entry (addr 5), done.
- Backpressure: first=2, last=4, ready low 5 cycles on entry 3 → entry 3 addr/data stable throughout; no skips or duplicates; order 2,3,4.
- Start while busy: second start with first=9 mid-dump of 0..3 → ignored; output exactly 0..3.
- Reset mid-dump: rst=1 during OUT of entry 7 of 0..15 →
  - Next cycle: dump_valid=0, busy=0, rf_rd_addr=0, done never pulses.
  - A fresh start 0..0 then works normally.
- RD_LAT=3 build, r[6]=0xDEADBEEF, start 6..6 → dump_valid rises 3 edges after start; data 0xDEADBEEF; rf_rd_addr held at 6 for all 3 READ cycles.

Source files
------------

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - sequential {address, data} dump of a 32x32 register file over a valid/ready stream
//
// Walks a contiguous, possibly wrapping, range of register addresses
// (first_addr .. last_addr, 5-bit arithmetic) through one register-file read
// port and presents each entry on dump_addr/dump_data with a valid/ready
// handshake. One entry is in flight at a time: read, wait RD_LAT cycles,
// hold until accepted, then advance.
//
// Parameters:
//   RD_LAT      register-file read latency in cycles (>= 1)
//
// Ports:
//   elk         clock, rising edge
//   rst         synchronous active-high reset, priority over everything
//   start       one-cycle dump request, honoured only when idle
//   first_addr  first register of the range, latched on accepted start
//   last_addr   last register of the range, latched on accepted start
//   busy        dump in progress (READ, OUT, DONE)
//   done        one-cycle pulse after the final transfer
//   rf_rd_addr  registered read address to the register file
//   rf_rd_data  read data, valid RD_LAT cycles after rf_rd_addr changes
//   dump_valid  dump_addr/dump_data hold a valid entry
//   dump_ready  downstream accepts the entry
//   dump_addr   register number of the current entry
//   dump_data   register contents of the current entry

module regfile_dump #(
    parameter int RD_LAT = 1
) (
    input  logic        elk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  first_addr,
    input  logic [4:0]  last_addr,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_addr,
    output logic [31:0] dump_data
);

    // Wait counter only has to hold RD_LAT-1; keep at least one bit.
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [4:0]    last_q;

    // busy/done/dump_valid are kept as their own flops, updated together
    // with the state, so every status output comes straight from a register.
    always_ff @(posedge elk) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            last_q     <= '0;
            rf_rd_addr <= '0;
            dump_addr  <= '0;
            dump_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dump_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done       <= 1'b0;
                    dump_valid <= 1'b0;
                    if (start) begin
                        rf_rd_addr <= first_addr;
                        last_q     <= last_addr;
                        wait_cnt   <= WAIT_INIT;
                        busy       <= 1'b1;
                        state      <= S_READ;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                // rf_rd_addr is held here; the read data is sampled on the
                // edge where the counter has run down to zero.
                S_READ: begin
                    if (wait_cnt == '0) begin
                        dump_data  <= rf_rd_data;
                        dump_addr  <= rf_rd_addr;
                        dump_valid <= 1'b1;
                        state      <= S_OUT;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_ONE;
                    end
                end

                // The transfer edge also issues the next read address.
                S_OUT: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (dump_addr == last_q) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            rf_rd_addr <= rf_rd_addr + 5'd1;
                            wait_cnt   <= WAIT_INIT;
                            state      <= S_READ;
                        end
                    end
                end

                // start is deliberately not looked at here.
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    dump_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - randomized self-checking bench for regfile_dump
module tb_regfile_dump;

    logic elk = 1'b0;
    always #5 elk = ~elk;

    logic        rst, start, dump_ready;
    logic [4:0]  first_addr, last_addr;
    logic        busy, done, dump_valid;
    logic [4:0]  rf_rd_addr, dump_addr;
    logic [31:0] rf_rd_data, dump_data;

    logic        start_3, dump_ready_3;
    logic [4:0]  first_addr_3, last_addr_3;
    logic        busy_3, done_3, dump_valid_3;
    logic [4:0]  rf_rd_addr_3, dump_addr_3;
    logic [31:0] rf_rd_data_3, dump_data_3;

    logic [31:0] rf [32];
    logic [31:0] pipe_1, pipe_2;

    int compared = 0;
    int mismatched = 0;

    logic [4:0]  got_addr [$];
    logic [31:0] got_data [$];

    regfile_dump #(.RD_LAT(1)) dut (
        .elk(elk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .done(done), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data)
    );

    regfile_dump #(.RD_LAT(3)) dut3 (
        .elk(elk), .rst(rst), .start(start_3), .first_addr(first_addr_3), .last_addr(last_addr_3),
        .busy(busy_3), .done(done_3), .rf_rd_addr(rf_rd_addr_3), .rf_rd_data(rf_rd_data_3),
        .dump_valid(dump_valid_3), .dump_ready(dump_ready_3), .dump_addr(dump_addr_3), .dump_data(dump_data_3)
    );

    // Register file with latency 1 (combinational read sampled next edge)
    // and latency 3 (two pipeline stages after the array read).
    always_comb rf_rd_data = rf[rf_rd_addr];
    always_ff @(posedge elk) begin
        pipe_1 <= rf[rf_rd_addr_3];
        pipe_2 <= pipe_1;
    end
    assign rf_rd_data_3 = pipe_2;

    // Runs one dump on the RD_LAT=1 instance. Caller is 1 time unit after a
    // rising edge with the DUT idle. Iteration k observes the cycle after
    // edge T0+k-1, where T0 is the start edge.
    task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int stall_pct,
                           input int stall_addr, input int stall_len, input int inject_at,
                           output int done_cnt, output int done_cyc, output int valid_cyc,
                           output int first_valid, output int unstable, output int busy_after,
                           output int timed_out);
        int held, stalls;
        logic [4:0]  ha;
        logic [31:0] hd;
        got_addr.delete();
        got_data.delete();
        done_cnt = 0; done_cyc = 0; valid_cyc = 0; first_valid = 0; unstable = 0;
        busy_after = 1; timed_out = 1; held = 0; stalls = 0; ha = '0; hd = '0;
        start = 1'b1; first_addr = f; last_addr = l; dump_ready = 1'b0;
        @(posedge elk); #1;
        start = 1'b0; first_addr = 5'($urandom); last_addr = 5'($urandom);
        for (int k = 1; k <= 2000; k++) begin
            if (done) begin
                done_cnt++;
                done_cyc = k;
            end else if (done_cnt > 0) begin
                busy_after = int'(busy);
                timed_out = 0;
                break;
            end
            if (dump_valid) begin
                valid_cyc++;
                if (first_valid == 0) first_valid = k;
                if (held != 0 && (dump_addr !== ha || dump_data !== hd)) unstable++;
            end else if (held != 0) begin
                unstable++;
            end
            start = (k == inject_at);
            if (k == inject_at) begin first_addr = 5'd9; last_addr = 5'd12; end
            if (stall_len > 0 && dump_valid && dump_addr == stall_addr[4:0] && stalls < stall_len) begin
                dump_ready = 1'b0;
                stalls++;
            end else if (stall_pct > 0) begin
                dump_ready = ($urandom_range(99) >= stall_pct);
            end else begin
                dump_ready = 1'b1;
            end
            if (dump_valid && dump_ready) begin
                got_addr.push_back(dump_addr);
                got_data.push_back(dump_data);
                held = 0;
            end else if (dump_valid) begin
                held = 1; ha = dump_addr; hd = dump_data;
            end else begin
                held = 0;
            end
            @(posedge elk); #1;
        end
        start = 1'b0;
        dump_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; first_addr = 5'd7; last_addr = 5'd9;
        repeat (3) @(posedge elk);
        #1;
        compared++; if ({busy, done, dump_valid} !== 3'b000) begin mismatched++; $display("FAIL reset_flags got %b want 000", {busy, done, dump_valid}); end
        compared++; if (rf_rd_addr !== 5'd0) begin mismatched++; $display("FAIL reset_rd_addr got %0d want 0", rf_rd_addr); end
        compared++; if (dump_addr !== 5'd0 || dump_data !== 32'd0) begin mismatched++; $display("FAIL reset_dump got %0d/%h want 0/0", dump_addr, dump_data); end
        compared++; if ({busy_3, done_3, dump_valid_3, rf_rd_addr_3} !== 8'd0) begin mismatched++; $display("FAIL reset_lat3 got %b want 0", {busy_3, done_3, dump_valid_3, rf_rd_addr_3}); end
        rst = 1'b0; start = 1'b0;
        @(posedge elk); #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    // Checks the collected entries against the range rule and the array.
    task automatic test_range(input string name, input logic [4:0] f, input logic [4:0] l,
                              input int stall_pct, input int inject_at);
        int dc, dcy, vc, fv, un, ba, to, n;
        logic [4:0] a;
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        do_dump(f, l, stall_pct, 0, 0, inject_at, dc, dcy, vc, fv, un, ba, to);
        compared++; if (to != 0) begin mismatched++; $display("FAIL %s_timeout got %0d want 0", name, to); end
        compared++; if (got_addr.size() != n) begin mismatched++; $display("FAIL %s_count got %0d want %0d", name, got_addr.size(), n); end
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            a = 5'((int'(f) + i) % 32);
            compared++;
            if (got_addr[i] !== a || got_data[i] !== rf[a]) begin
                mismatched++;
                $display("FAIL %s_entry%0d got %0d/%h want %0d/%h", name, i, got_addr[i], got_data[i], a, rf[a]);
            end
        end
        compared++; if (dc != 1) begin mismatched++; $display("FAIL %s_done_count got %0d want 1", name, dc); end
        compared++; if (un != 0) begin mismatched++; $display("FAIL %s_stable got %0d want 0", name, un); end
        compared++; if (ba != 0) begin mismatched++; $display("FAIL %s_busy_after got %0d want 0", name, ba); end
    endtask

    task automatic test_full_dump();
        int dc, dcy, vc, fv, un, ba, to;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h1111_1111;
        do_dump(5'd0, 5'd31, 0, 0, 0, 0, dc, dcy, vc, fv, un, ba, to);
        compared++; if (got_addr.size() != 32) begin mismatched++; $display("FAIL full_count got %0d want 32", got_addr.size()); end
        for (int i = 0; i < 32 && i < got_addr.size(); i++) begin
            compared++;
            if (got_addr[i] !== 5'(i) || got_data[i] !== 32'(i) * 32'h1111_1111) begin
                mismatched++;
                $display("FAIL full_entry%0d got %0d/%h want %0d/%h", i, got_addr[i], got_data[i], i, 32'(i) * 32'h1111_1111);
            end
        end
        compared++; if (dc != 1 || dcy != 65) begin mismatched++; $display("FAIL full_done got count %0d cycle %0d want 1 at 65", dc, dcy); end
        compared++; if (vc != 32 || fv != 2) begin mismatched++; $display("FAIL full_valid got %0d cycles first %0d want 32 first 2", vc, fv); end
        compared++; if (ba != 0 || to != 0) begin mismatched++; $display("FAIL full_end got busy %0d timeout %0d want 0 0", ba, to); end
    endtask

    task automatic test_backpressure();
        int dc, dcy, vc, fv, un, ba, to;
        do_dump(5'd2, 5'd4, 0, 3, 5, 0, dc, dcy, vc, fv, un, ba, to);
        compared++; if (got_addr.size() != 3) begin mismatched++; $display("FAIL bp_count got %0d want 3", got_addr.size()); end
        for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
            compared++;
            if (got_addr[i] !== 5'(i + 2) || got_data[i] !== rf[i + 2]) begin
                mismatched++;
                $display("FAIL bp_entry%0d got %0d/%h want %0d/%h", i, got_addr[i], got_data[i], i + 2, rf[i + 2]);
            end
        end
        compared++; if (un != 0 || vc != 8) begin mismatched++; $display("FAIL bp_stall got unstable %0d valid %0d want 0 8", un, vc); end
        compared++; if (dc != 1 || ba != 0) begin mismatched++; $display("FAIL bp_done got %0d busy %0d want 1 0", dc, ba); end
    endtask

    task automatic test_reset_mid_dump();
        int found, dones, dc, dcy, vc, fv, un, ba, to;
        found = 0;
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd15; dump_ready = 1'b1;
        @(posedge elk); #1;
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (dump_valid && dump_addr == 5'd7) begin found = 1; break; end
            @(posedge elk); #1;
        end
        compared++; if (found != 1) begin mismatched++; $display("FAIL rstmid_reach got %0d want 1", found); end
        rst = 1'b1;
        @(posedge elk); #1;
        rst = 1'b0;
        compared++; if ({dump_valid, busy, done} !== 3'b000) begin mismatched++; $display("FAIL rstmid_flags got %b want 000", {dump_valid, busy, done}); end
        compared++; if (rf_rd_addr !== 5'd0 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin mismatched++; $display("FAIL rstmid_regs got %0d/%0d/%h want 0/0/0", rf_rd_addr, dump_addr, dump_data); end
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy || dump_valid) dones++;
            @(posedge elk); #1;
        end
        compared++; if (dones != 0) begin mismatched++; $display("FAIL rstmid_quiet got %0d active cycles want 0", dones); end
        dump_ready = 1'b0;
        do_dump(5'd0, 5'd0, 0, 0, 0, 0, dc, dcy, vc, fv, un, ba, to);
        compared++; if (got_addr.size() != 1 || dc != 1) begin mismatched++; $display("FAIL rstmid_restart got %0d entries %0d dones want 1 1", got_addr.size(), dc); end
        else begin
            compared++; if (got_addr[0] !== 5'd0 || got_data[0] !== rf[0]) begin mismatched++; $display("FAIL rstmid_entry got %0d/%h want 0/%h", got_addr[0], got_data[0], rf[0]); end
        end
    endtask

    task automatic test_random();
        logic [4:0] f, l;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            f = 5'($urandom);
            l = 5'($urandom);
            test_range($sformatf("rand%0d", r), f, l, 30, 0);
        end
    endtask

    task automatic test_rd_lat3();
        int ok_addr;
        rf[0] = 32'h1234_5678;
        rf[6] = 32'hDEAD_BEEF;
        repeat (4) @(posedge elk);
        #1;
        start_3 = 1'b1; first_addr_3 = 5'd6; last_addr_3 = 5'd6; dump_ready_3 = 1'b0;
        @(posedge elk); #1;
        start_3 = 1'b0; first_addr_3 = 5'd20; last_addr_3 = 5'd21;
        ok_addr = 1;
        for (int k = 1; k <= 3; k++) begin
            if (rf_rd_addr_3 !== 5'd6 || dump_valid_3 !== 1'b0 || busy_3 !== 1'b1) ok_addr = 0;
            @(posedge elk); #1;
        end
        compared++; if (ok_addr != 1) begin mismatched++; $display("FAIL lat3_read_hold got %0d want 1", ok_addr); end
        compared++; if (dump_valid_3 !== 1'b1) begin mismatched++; $display("FAIL lat3_valid got %b want 1", dump_valid_3); end
        compared++; if (dump_addr_3 !== 5'd6 || dump_data_3 !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL lat3_entry got %0d/%h want 6/deadbeef", dump_addr_3, dump_data_3); end
        dump_ready_3 = 1'b1;
        @(posedge elk); #1;
        dump_ready_3 = 1'b0;
        compared++; if (done_3 !== 1'b1 || dump_valid_3 !== 1'b0) begin mismatched++; $display("FAIL lat3_done got %b/%b want 1/0", done_3, dump_valid_3); end
        @(posedge elk); #1;
        compared++; if (done_3 !== 1'b0 || busy_3 !== 1'b0) begin mismatched++; $display("FAIL lat3_idle got %b/%b want 0/0", done_3, busy_3); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; dump_ready = 1'b0; first_addr = '0; last_addr = '0;
        start_3 = 1'b0; dump_ready_3 = 1'b0; first_addr_3 = '0; last_addr_3 = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h1111_1111;
        test_reset();
        test_full_dump();
        test_range("wrap", 5'd30, 5'd1, 0, 0);
        test_range("single", 5'd5, 5'd5, 0, 0);
        test_backpressure();
        test_range("start_busy", 5'd0, 5'd3, 0, 3);
        test_reset_mid_dump();
        test_random();
        test_rd_lat3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
